// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one combinational ROM read port between two burst requesters.
//   Bursts are granted round-robin; the arbiter walks the ROM address for
//   the granted burst, registers each ROM word and returns it to the owner
//   with a per-requester valid strobe and a done pulse on the last word.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req0/addr0/len0       requester 0 burst request, start address, length-1
//   req1/addr1/len1       requester 1 burst request, start address, length-1
//   ack0, ack1            one-cycle burst-accepted pulses
//   rd_valid0, rd_valid1  rd_data carries a word for requester 0 / 1
//   done0, done1          asserted with the last word of a burst
//   rd_data               registered ROM word (shared by both requesters)
//   busy                  high while a burst is being read
//   rom_addr, rom_en      ROM address and enable
//   rom_data              combinational ROM output
module rom_read_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [LEN_W-1:0]  len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len1,
    output logic              ack0,
    output logic              ack1,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);

    state_t            state;
    state_t            next_state;
    logic              owner;
    logic              last_gnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  cnt;

    logic              gnt_valid;
    logic              winner;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and round-robin arbitration.
    // With both requests pending, the requester that did not win last time
    // is chosen; last_gnt resets to 1 so requester 0 wins first.
    always_comb begin
        gnt_valid  = req0 | req1;
        winner     = (req0 && req1) ? ~last_gnt : req1;
        next_state = state;
        case (state)
            IDLE: if (gnt_valid) next_state = READ;
            READ: if (cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state == READ);
        rom_en   = (state == READ);
        rom_addr = cur_addr;
    end

    // Datapath and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            cur_addr  <= '0;
            cnt       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rd_data   <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner    <= winner;
                        last_gnt <= winner;
                        cur_addr <= winner ? addr1 : addr0;
                        cnt      <= winner ? len1 : len0;
                        ack0     <= ~winner;
                        ack1     <= winner;
                    end
                end
                READ: begin
                    rd_data   <= rom_data;
                    rd_valid0 <= ~owner;
                    rd_valid1 <= owner;
                    cur_addr  <= cur_addr + ADDR_ONE;
                    if (cnt == '0) begin
                        done0 <= ~owner;
                        done1 <= owner;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
